// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI write/read transaction arbiter.
package axi_arb_pkg;

  localparam int unsigned NumMasters           = 2;
  localparam int unsigned IdxW                 = 1;
  localparam int unsigned TimeoutCyclesDefault = 1024;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  // One-hot grant to master index; all-zero maps to index 0.
  function automatic logic [IdxW-1:0] oh_to_idx(input logic [NumMasters-1:0] oh);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NumMasters; i++) begin
      if (oh[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: the first requester after the last winner wins.
module arb_rr_pick
  import axi_arb_pkg::*;
(
  input  logic [NumMasters-1:0] req_i,
  input  logic [IdxW-1:0]       last_i,
  output logic [NumMasters-1:0] winner_o
);

  int unsigned idx;

  // Scan from farthest to nearest offset so the nearest requester overrides.
  always_comb begin
    winner_o = '0;
    idx      = 0;
    for (int unsigned k = NumMasters; k >= 1; k--) begin
      idx = (32'(last_i) + k) % NumMasters;
      if (req_i[idx]) begin
        winner_o      = '0;
        winner_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_txn_arbiter.sv
// Independent write/read transaction arbiters for two AXI masters sharing one slave.
// Optional forced-release timeout is enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_txn_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic [NumMasters-1:0] m_awvalid,
  input  logic [NumMasters-1:0] m_wvalid,
  input  logic [NumMasters-1:0] m_bready,
  input  logic                  s_awready,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [NumMasters-1:0] m_arvalid,
  input  logic [NumMasters-1:0] m_rready,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  output logic [NumMasters-1:0] grant_w,
  output logic [NumMasters-1:0] grant_r,
  output logic                  timeout_err_w,
  output logic                  timeout_err_r
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic [NumMasters-1:0] grant_w_q, grant_w_d, grant_r_q, grant_r_d;
  logic [IdxW-1:0]       last_w_q, last_w_d, last_r_q, last_r_d;
  logic                  aw_done_q, aw_done_d, wd_done_q, wd_done_d;
  logic [NumMasters-1:0] pick_w, pick_r;
  logic                  aw_hs, wd_hs, b_hs, ar_hs, r_hs;
  logic                  to_w, to_r;

  arb_rr_pick u_pick_w (.req_i(m_awvalid), .last_i(last_w_q), .winner_o(pick_w));
  arb_rr_pick u_pick_r (.req_i(m_arvalid), .last_i(last_r_q), .winner_o(pick_r));

  // Only the granted master's handshakes count.
  assign aw_hs = (|(m_awvalid & grant_w_q)) & s_awready;
  assign wd_hs = (|(m_wvalid & grant_w_q)) & s_wready;
  assign b_hs  = (|(m_bready & grant_w_q)) & s_bvalid;
  assign ar_hs = (|(m_arvalid & grant_r_q)) & s_arready;
  assign r_hs  = (|(m_rready & grant_r_q)) & s_rvalid;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_w_q, cnt_w_d, cnt_r_q, cnt_r_d;

  // Counters sit at zero in IDLE and count every busy cycle.
  always_comb begin
    cnt_w_d = (w_state_q == W_IDLE) ? '0 : cnt_w_q + 1'b1;
    cnt_r_d = (r_state_q == R_IDLE) ? '0 : cnt_r_q + 1'b1;
  end

  // Timeout counter registers.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_w_q <= '0;
      cnt_r_q <= '0;
    end else begin
      cnt_w_q <= cnt_w_d;
      cnt_r_q <= cnt_r_d;
    end
  end

  // A completing handshake on the last allowed cycle still wins over the timeout.
  assign to_w = (w_state_q != W_IDLE) && (cnt_w_q == CntMax) && !((w_state_q == W_RESP) && b_hs);
  assign to_r = (r_state_q != R_IDLE) && (cnt_r_q == CntMax) && !((r_state_q == R_DATA) && r_hs);
`else
  assign to_w = 1'b0;
  assign to_r = 1'b0;
`endif

  assign timeout_err_w = to_w;
  assign timeout_err_r = to_r;
  assign grant_w       = grant_w_q;
  assign grant_r       = grant_r_q;

  // Write FSM next state: grant on request, track AW/W separately, release on B.
  always_comb begin
    w_state_d = w_state_q;
    grant_w_d = grant_w_q;
    last_w_d  = last_w_q;
    aw_done_d = aw_done_q;
    wd_done_d = wd_done_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (|m_awvalid) begin
          w_state_d = W_ADDR;
          grant_w_d = pick_w;
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
        end
      end
      W_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        wd_done_d = wd_done_q | wd_hs;
        if (aw_done_d && wd_done_d) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
          grant_w_d = '0;
          last_w_d  = oh_to_idx(grant_w_q);
        end
      end
      default: begin
        w_state_d = W_IDLE;
        grant_w_d = '0;
      end
    endcase
    if (to_w) begin
      w_state_d = W_IDLE;
      grant_w_d = '0;
      last_w_d  = oh_to_idx(grant_w_q);
      aw_done_d = 1'b0;
      wd_done_d = 1'b0;
    end
  end

  // Read FSM next state: grant on request, AR then one R beat, release.
  always_comb begin
    r_state_d = r_state_q;
    grant_r_d = grant_r_q;
    last_r_d  = last_r_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (|m_arvalid) begin
          r_state_d = R_ADDR;
          grant_r_d = pick_r;
        end
      end
      R_ADDR: begin
        if (ar_hs) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (r_hs) begin
          r_state_d = R_IDLE;
          grant_r_d = '0;
          last_r_d  = oh_to_idx(grant_r_q);
        end
      end
      default: begin
        r_state_d = R_IDLE;
        grant_r_d = '0;
      end
    endcase
    if (to_r) begin
      r_state_d = R_IDLE;
      grant_r_d = '0;
      last_r_d  = oh_to_idx(grant_r_q);
    end
  end

  // State registers; last winner resets to the highest index so master 0 wins first.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      grant_w_q <= '0;
      grant_r_q <= '0;
      last_w_q  <= IdxW'(NumMasters - 1);
      last_r_q  <= IdxW'(NumMasters - 1);
      aw_done_q <= 1'b0;
      wd_done_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      grant_w_q <= grant_w_d;
      grant_r_q <= grant_r_d;
      last_w_q  <= last_w_d;
      last_r_q  <= last_r_d;
      aw_done_q <= aw_done_d;
      wd_done_q <= wd_done_d;
    end
  end

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Self-checking bench for axi_txn_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level model. Honours AXI_ARB_TIMEOUT_EN.
module tb_axi_txn_arbiter;

  localparam int TO = 16;
`ifdef AXI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       aclk = 1'b0;
  logic       rst_n;
  logic [1:0] m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic       s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] grant_w, grant_r;
  logic       timeout_err_w, timeout_err_r;

  axi_txn_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .aclk          (aclk),
    .rst_n         (rst_n),
    .m_awvalid     (m_awvalid),
    .m_wvalid      (m_wvalid),
    .m_bready      (m_bready),
    .s_awready     (s_awready),
    .s_wready      (s_wready),
    .s_bvalid      (s_bvalid),
    .m_arvalid     (m_arvalid),
    .m_rready      (m_rready),
    .s_arready     (s_arready),
    .s_rvalid      (s_rvalid),
    .grant_w       (grant_w),
    .grant_r       (grant_r),
    .timeout_err_w (timeout_err_w),
    .timeout_err_r (timeout_err_r)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Transaction-level model: owner -1 means nobody holds the channel.
  int w_own, r_own, w_last, r_last, w_age, r_age;
  bit w_aw, w_w, w_resp, r_data;

  function automatic int pick(input logic [1:0] req, input int last);
    if (req == 2'b11) return 1 - last;
    return req[1] ? 1 : 0;
  endfunction

  task automatic mdl_reset();
    w_own = -1; r_own = -1; w_last = 1; r_last = 1; w_age = 0; r_age = 0;
    w_aw = 0; w_w = 0; w_resp = 0; r_data = 0;
  endtask

  task automatic idle_inputs();
    m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0; m_rready = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
  endtask

  // One clock: check this cycle's pulses, advance model, check grants after the edge.
  task automatic step();
    bit fin_w, fin_r, to_w, to_r;
    #1;
    fin_w = (w_own >= 0) && w_resp && s_bvalid && m_bready[w_own];
    fin_r = (r_own >= 0) && r_data && s_rvalid && m_rready[r_own];
    to_w  = TO_EN && (w_own >= 0) && (w_age == TO - 1) && !fin_w;
    to_r  = TO_EN && (r_own >= 0) && (r_age == TO - 1) && !fin_r;
    check_eq("timeout_err_w", 32'(timeout_err_w), 32'(to_w));
    check_eq("timeout_err_r", 32'(timeout_err_r), 32'(to_r));
    if (w_own < 0) begin
      if (m_awvalid != 0) begin
        w_own = pick(m_awvalid, w_last); w_aw = 0; w_w = 0; w_resp = 0; w_age = 0;
      end
    end else if (fin_w || to_w) begin
      w_last = w_own; w_own = -1;
    end else begin
      if (!w_resp) begin
        w_aw = w_aw || (m_awvalid[w_own] && s_awready);
        w_w  = w_w || (m_wvalid[w_own] && s_wready);
        if (w_aw && w_w) w_resp = 1;
      end
      w_age++;
    end
    if (r_own < 0) begin
      if (m_arvalid != 0) begin
        r_own = pick(m_arvalid, r_last); r_data = 0; r_age = 0;
      end
    end else if (fin_r || to_r) begin
      r_last = r_own; r_own = -1;
    end else begin
      if (!r_data && m_arvalid[r_own] && s_arready) r_data = 1;
      r_age++;
    end
    @(posedge aclk);
    #1;
    check_eq("grant_w", 32'(grant_w), (w_own < 0) ? 0 : (1 << w_own));
    check_eq("grant_r", 32'(grant_r), (r_own < 0) ? 0 : (1 << r_own));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_eq("rst_grant_w", 32'(grant_w), 0);
    check_eq("rst_grant_r", 32'(grant_r), 0);
    check_eq("rst_err", 32'({timeout_err_w, timeout_err_r}), 0);
    mdl_reset();
    @(posedge aclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    mdl_reset();
    rst_n = 1'b0;
    #12;
    check_eq("reset_grant_w", 32'(grant_w), 0);
    check_eq("reset_grant_r", 32'(grant_r), 0);
    check_eq("reset_err", 32'({timeout_err_w, timeout_err_r}), 0);
    @(posedge aclk);
    #1;
    rst_n = 1'b1;

    // Single write by master 0, then contention proves last_w became 0.
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01; s_awready = 1; s_wready = 1;
    step();
    check_eq("a_grant", 32'(grant_w), 32'h1);
    step();
    m_awvalid = 0; m_wvalid = 0; s_bvalid = 1;
    step();
    check_eq("a_release", 32'(grant_w), 0);
    s_bvalid = 0; m_awvalid = 2'b11;
    step();
    check_eq("a_last_w0", 32'(grant_w), 32'h2);

    // Both masters keep requesting: grants alternate with one idle bubble.
    do_reset();
    m_awvalid = 2'b11; m_wvalid = 2'b11; m_bready = 2'b11;
    s_awready = 1; s_wready = 1; s_bvalid = 1;
    for (int k = 0; k < 12; k++) begin
      step();
      check_eq("b_alternate", 32'(grant_w), (k % 3 == 2) ? 0 : (((k / 3) % 2 == 1) ? 2 : 1));
    end

    // W accepted three cycles before AW: the B response must not be taken early.
    do_reset();
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01; s_wready = 1; s_bvalid = 1;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("c_hold", 32'(grant_w), 32'h1);
    end
    s_awready = 1;
    step();
    check_eq("c_resp_entered", 32'(grant_w), 32'h1);
    step();
    check_eq("c_done", 32'(grant_w), 0);

    // Concurrent write by master 0 and read by master 1.
    do_reset();
    m_awvalid = 2'b01; m_wvalid = 2'b01; s_awready = 1; s_wready = 1;
    m_arvalid = 2'b10; s_arready = 1;
    step();
    check_eq("d_grant_w", 32'(grant_w), 32'h1);
    check_eq("d_grant_r", 32'(grant_r), 32'h2);
    step();
    m_awvalid = 0; m_wvalid = 0; m_arvalid = 0; s_bvalid = 1; m_bready = 2'b01;
    step();
    check_eq("d_w_done", 32'(grant_w), 0);
    check_eq("d_r_held", 32'(grant_r), 32'h2);
    s_rvalid = 1; m_rready = 2'b10;
    step();
    check_eq("d_r_done", 32'(grant_r), 0);

    // Read whose data never arrives.
    do_reset();
    m_arvalid = 2'b01; s_arready = 1; m_rready = 2'b01;
    step();
    check_eq("e_grant", 32'(grant_r), 32'h1);
    m_arvalid = 0;
    for (int k = 0; k < 15; k++) step();
`ifdef AXI_ARB_TIMEOUT_EN
    #1;
    check_eq("e_err_pulse", 32'(timeout_err_r), 1);
    step();
    check_eq("e_released", 32'(grant_r), 0);
`else
    for (int k = 0; k < 10; k++) step();
    check_eq("e_held", 32'(grant_r), 32'h1);
`endif

    // Reset asserted while waiting for B abandons the transaction.
    do_reset();
    m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10; s_awready = 1; s_wready = 1;
    step();
    step();
    check_eq("f_in_resp", 32'(grant_w), 32'h2);
    do_reset();
    m_awvalid = 2'b11;
    step();
    check_eq("f_master0_wins", 32'(grant_w), 32'h1);

    // Randomized traffic on both channels.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      m_awvalid = 2'($urandom); m_wvalid = 2'($urandom); m_bready = 2'($urandom);
      m_arvalid = 2'($urandom); m_rready = 2'($urandom);
      s_awready = ($urandom_range(0, 3) != 0); s_wready = ($urandom_range(0, 3) != 0);
      s_bvalid  = ($urandom_range(0, 2) == 0); s_arready = ($urandom_range(0, 3) != 0);
      s_rvalid  = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
